// File: rtl/fft_frame_loader.sv
// Frame capture buffer feeding the FFT: capture FFT_SIZE samples, stream them out, start, wait.
// Optional DC-blocking front end when FFT_DC_BLOCK_EN is defined.
module fft_frame_loader #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned N         = 9,
    parameter int unsigned FFT_SIZE  = 512,
    parameter int unsigned DECIM     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [BIT_WIDTH-1:0] sample,
    input  logic                 fft_done,
    output logic                 fft_load,
    output logic [BIT_WIDTH-1:0] din,
    output logic                 fft_start,
    output logic                 frame_ready,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [1:0] {StCapture, StLoad, StStart, StWait} state_e;

    localparam logic [N-1:0] LastIdx   = N'(FFT_SIZE - 1);
    localparam logic [3:0]   DecimLast = 4'(DECIM - 1);

    state_e               state;
    logic [N-1:0]         wr_cnt;
    logic [N-1:0]         rd_cnt;
    logic [3:0]           decim_cnt;
    logic                 kept;
    logic                 capture_wr;
    logic [BIT_WIDTH-1:0] wr_data;
    logic [BIT_WIDTH-1:0] frame_buf [FFT_SIZE];

    assign kept       = sample_valid && (decim_cnt == 4'd0);
    assign capture_wr = kept && (state == StCapture);

`ifdef FFT_DC_BLOCK_EN
    localparam int unsigned DW = BIT_WIDTH + 6;

    // dc carries 6 fractional bits; the integer part is dc[DW-1:6].
    logic signed [DW-1:0]      dc;
    logic signed [DW:0]        dc_diff;
    logic signed [BIT_WIDTH:0] dc_sub;

    always_comb begin
        dc_diff = $signed({sample[BIT_WIDTH-1], sample, 6'b0}) - $signed({dc[DW-1], dc});
        dc_sub  = $signed({sample[BIT_WIDTH-1], sample}) - $signed({dc[DW-1], dc[DW-1:6]});
        if (dc_sub[BIT_WIDTH] != dc_sub[BIT_WIDTH-1]) begin
            wr_data = dc_sub[BIT_WIDTH] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(BIT_WIDTH-1){1'b1}}};
        end else begin
            wr_data = dc_sub[BIT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dc <= '0;
        end else if (capture_wr) begin
            dc <= dc + DW'(dc_diff >>> 6);
        end
    end
`else
    assign wr_data = sample;
`endif

    // Buffer kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (capture_wr) begin
            frame_buf[wr_cnt] <= wr_data;
        end
    end

    // din doubles as the RAM output register and holds while not loading.
    always_ff @(posedge clk) begin
        if (reset) begin
            din <= '0;
        end else if (state == StLoad) begin
            din <= frame_buf[rd_cnt];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StCapture;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            decim_cnt   <= '0;
            fft_load    <= 1'b0;
            fft_start   <= 1'b0;
            frame_ready <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            fft_load    <= 1'b0;
            fft_start   <= 1'b0;
            frame_ready <= 1'b0;

            if (sample_valid) begin
                decim_cnt <= (decim_cnt == DecimLast) ? 4'd0 : decim_cnt + 4'd1;
            end
            if (kept && state != StCapture) begin
                overrun <= 1'b1;
            end

            case (state)
                StCapture: begin
                    if (kept) begin
                        if (wr_cnt == LastIdx) begin
                            wr_cnt <= '0;
                            state  <= StLoad;
                            busy   <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + N'(1);
                        end
                    end
                end
                StLoad: begin
                    fft_load <= 1'b1;
                    if (rd_cnt == LastIdx) begin
                        rd_cnt <= '0;
                        state  <= StStart;
                    end else begin
                        rd_cnt <= rd_cnt + N'(1);
                    end
                end
                StStart: begin
                    fft_start <= 1'b1;
                    state     <= StWait;
                end
                StWait: begin
                    // Ignore done during the start-pulse cycle so a stale level is not taken.
                    if (fft_done && !fft_start) begin
                        frame_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= StCapture;
                    end
                end
                default: state <= StCapture;
            endcase
        end
    end

endmodule
